mio_bus_ctrl: RTL
=================

Name: mio_bus_ctrl

Overview:
- Memory/IO bus controller directly downstream of the single-cycle CPU.
- Consumes the CPU's bus request (address, write data, write enable, MIO strobe) and decodes it to block RAM, the LED/switch GPIO port, or a free-running counter.
- Returns read data plus a one-cycle ready pulse, which the CPU uses as Data_in / MIO_ready.
- Owns the RAM access wait state, so RAM latency can change without touching the CPU.

Parameters:
- RAM_AW, 10, RAM word-address width (RAM holds 2^RAM_AW 32-bit words).
- RAM_LAT, 1, RAM read latency in cycles, legal range 1..4.
- IO_W, 16, width of the LED output and switch input.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  bus request (CPU_MIO); held high with addr/we/wdata stable until cpu_ready.
- cpu_we  in  1  1 = write, 0 = read (mem_w).
- cpu_addr  in  32  byte address (Addr_out); addr[1:0] ignored, word access only.
- cpu_wdata  in  32  write data (Data_out).
- cpu_rdata  out  32  registered read data (to Data_in).
- cpu_ready  out  1  one-cycle completion pulse (to MIO_ready).
- ram_addr  out  RAM_AW  word address = cpu_addr[RAM_AW+1:2], combinational.
- ram_wdata  out  32  = cpu_wdata, combinational.
- ram_we  out  1  RAM write strobe.
- ram_rdata  in  32  RAM read data, valid RAM_LAT cycles after address.
- sw_in  in  IO_W  switch inputs.
- led_out  out  IO_W  LED register.
- bus_err  out  1  sticky unmapped-access flag.

Behaviour:
- Reset (async, active-high): state = IDLE, cpu_ready = 0, cpu_rdata = 0, ram_we = 0, led_out = 0, counter = 0, bus_err = 0. Reset mid-transaction aborts it; no ready is issued.
- Address map (decode on cpu_addr):
  - RAM: addr[31:28] == 0. Upper bits above RAM_AW+1 are ignored, so the region aliases.
  - GPIO: addr == 0xE000_0000. Read returns zero-extended sw_in; write sets led_out <= wdata[IO_W-1:0].
  - COUNTER: addr == 0xF000_0004. Read returns the counter; write loads the counter with wdata.
  - Anything else is unmapped: read returns 0, write is dropped, bus_err is set to 1 until reset.
- Counter: 32-bit, increments by 1 every cycle and wraps 0xFFFF_FFFF -> 0. A write load wins over increment in that cycle; the next cycle continues from the loaded value + 1.
- FSM states: IDLE, RAM_ACC, RESP.
  - IDLE, cpu_req = 0: stay in IDLE.
  - IDLE, cpu_req = 1, RAM region: go to RAM_ACC and load wait counter = RAM_LAT-1 for a read, 0 for a write.
  - IDLE, cpu_req = 1, GPIO/COUNTER/unmapped: perform the access at this edge (write commit, or cpu_rdata capture) and go to RESP.
  - RAM_ACC: ram_we = cpu_we in the first RAM_ACC cycle only, 0 otherwise. The state decrements the wait counter. When the counter is 0, a read captures cpu_rdata <= ram_rdata, then the FSM goes to RESP.
  - RESP: cpu_ready = 1 for exactly this cycle, then always IDLE.
- Latency, counted from the accepting edge to the cycle cpu_ready is high:
  - IO and unmapped: 1 cycle.
  - RAM write: 2 cycles.
  - RAM read: RAM_LAT+1 cycles.
- Back-to-back requests: a request still high in the IDLE cycle after RESP is accepted then. Minimum issue interval is 2 cycles (IO) or RAM_LAT+2 cycles (RAM read).
- Request dropped mid-transaction: the transaction completes anyway, including a RAM write that is already committed, and ready still pulses. Requests are sampled only in IDLE.
- cpu_rdata holds its last captured value between transactions. Writes do not change cpu_rdata.
- cpu_ready, cpu_rdata, led_out and bus_err are all registered outputs. ram_we is decoded from state only, never directly from cpu_req.

Test Plan:
- Reset then idle 5 cycles -> cpu_ready = 0 throughout; led_out = 0, bus_err = 0; counter read at addr 0xF000_0004 returns a small nonzero value equal to cycles since reset.
- Write 0x1234_5678 to 0x0000_0010, then read 0x0000_0010 with RAM_LAT = 2 -> ram_we high for one cycle with ram_addr = 4; read asserts cpu_ready 3 cycles after acceptance; cpu_rdata = 0x1234_5678.
- Write 0x0000_A5A5 to 0xE000_0000; read it with sw_in = 0x00FF -> led_out = 0xA5A5 after 1 cycle; read returns 0x0000_00FF; ready latency 1.
- Write 0xFFFF_FFFE to counter, read 3 cycles later -> value wrapped past 0xFFFF_FFFF, equals loaded value + elapsed cycles mod 2^32.
- Read 0x8000_0000 -> cpu_rdata = 0, cpu_ready pulses, bus_err = 1 and stays set across later valid accesses until reset.
- Assert reset during RAM_ACC of a read -> no cpu_ready; all outputs return to reset values immediately; the next request completes normally.

Source files
------------

// File: rtl/mio_bus_ctrl.sv
// Memory/IO bus controller: decodes CPU requests to block RAM, GPIO or a free-running counter,
// and returns registered read data with a one-cycle ready pulse.
module mio_bus_ctrl #(
  parameter int unsigned RAM_AW  = 10,
  parameter int unsigned RAM_LAT = 1,
  parameter int unsigned IO_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ready,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_we,
  input  logic [31:0]       ram_rdata,
  input  logic [IO_W-1:0]   sw_in,
  output logic [IO_W-1:0]   led_out,
  output logic              bus_err
);

  localparam logic [31:0] GpioAddr = 32'hE000_0000;
  localparam logic [31:0] CntAddr  = 32'hF000_0004;

  typedef enum logic [1:0] {StIdle, StRamAcc, StResp} state_e;

  state_e            state_q, state_d;
  logic [1:0]        wait_q, wait_d;
  logic              we_q, we_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic [IO_W-1:0]   led_q, led_d;
  logic [31:0]       cnt_q, cnt_d;
  logic              err_q, err_d;

  logic is_ram, is_gpio, is_cnt;
  logic unused_addr_lsb;

  // Byte-lane bits are don't-care: all accesses are whole words.
  assign unused_addr_lsb = ^cpu_addr[1:0];

  assign is_ram  = (cpu_addr[31:28] == 4'h0);
  assign is_gpio = (cpu_addr[31:2] == GpioAddr[31:2]);
  assign is_cnt  = (cpu_addr[31:2] == CntAddr[31:2]);

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    led_d   = led_q;
    err_d   = err_q;
    cnt_d   = cnt_q + 32'd1;
    unique case (state_q)
      StIdle: begin
        if (cpu_req) begin
          if (is_ram) begin
            state_d = StRamAcc;
            we_d    = cpu_we;
            wait_d  = cpu_we ? 2'd0 : 2'(RAM_LAT - 1);
          end else begin
            state_d = StResp;
            if (is_gpio) begin
              if (cpu_we) led_d = cpu_wdata[IO_W-1:0];
              else        rdata_d = 32'(sw_in);
            end else if (is_cnt) begin
              // A load takes priority over this cycle's increment.
              if (cpu_we) cnt_d = cpu_wdata;
              else        rdata_d = cnt_q;
            end else begin
              err_d = 1'b1;
              if (!cpu_we) rdata_d = '0;
            end
          end
        end
      end
      StRamAcc: begin
        if (wait_q == 2'd0) begin
          if (!we_q) rdata_d = ram_rdata;
          state_d = StResp;
        end else begin
          wait_d = wait_q - 2'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    ready_d = (state_d == StResp);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      wait_q  <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      led_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      led_q   <= led_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Writes always spend a single RAM_ACC cycle, so the strobe is one cycle wide.
  assign ram_we    = (state_q == StRamAcc) && we_q;
  assign ram_addr  = cpu_addr[RAM_AW+1:2];
  assign ram_wdata = cpu_wdata;
  assign cpu_rdata = rdata_q;
  assign cpu_ready = ready_q;
  assign led_out   = led_q;
  assign bus_err   = err_q;

endmodule
